// File: rtl/ram_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_bist_pkg
// Description : Shared state encoding, March element ids and pattern helpers.
// Revision    : 1.0
// ============================================================================
package ram_bist_pkg;

    localparam int MAX_WIDTH = 256;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_W0      = 4'd1,
        ST_R0W1_RD = 4'd2,
        ST_R0W1_WR = 4'd3,
        ST_R1W0_RD = 4'd4,
        ST_R1W0_WR = 4'd5,
        ST_R0_RD   = 4'd6,
        ST_R0_CMP  = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        EL_NONE = 3'd0,
        EL_W0   = 3'd1,
        EL_R0W1 = 3'd2,
        EL_R1W0 = 3'd3,
        EL_R0   = 3'd4
    } element_t;

    function automatic element_t element_of(input state_t s);
        element_t e;
        e = EL_NONE;
        case (s)
            ST_W0:                   e = EL_W0;
            ST_R0W1_RD, ST_R0W1_WR:  e = EL_R0W1;
            ST_R1W0_RD, ST_R1W0_WR:  e = EL_R1W0;
            ST_R0_RD, ST_R0_CMP:     e = EL_R0;
            default:                 e = EL_NONE;
        endcase
        return e;
    endfunction

    // Callers size-cast the result down to their own word width.
    function automatic logic [MAX_WIDTH-1:0] pattern(input logic ones, input int width);
        logic [MAX_WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                p[i] = ones;
            end
        end
        return p;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] p0_pattern(input int width);
        return pattern(1'b0, width);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] p1_pattern(input int width);
        return pattern(1'b1, width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_bist_ctrl_if
// Description : Control handshake and RAM port of the BIST controller.
//               Error-log signals exist only with RAM_BIST_ERRLOG_EN.
// Revision    : 1.0
// ============================================================================
interface ram_bist_ctrl_if #(
    parameter int data_width = 8,
    parameter int data_addr  = 4
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic                  ram_we;
    logic [data_addr-1:0]  ram_addr;
    logic [data_width-1:0] ram_data_in;
    logic [data_width-1:0] ram_data_out;
`ifdef RAM_BIST_ERRLOG_EN
    logic [data_addr-1:0]  fail_addr;
    logic [data_width-1:0] fail_data;

    modport master (
        input  start, ram_data_out,
        output busy, done, pass, ram_we, ram_addr, ram_data_in, fail_addr, fail_data
    );
    modport slave (
        output start, ram_data_out,
        input  busy, done, pass, ram_we, ram_addr, ram_data_in, fail_addr, fail_data
    );
`else
    modport master (
        input  start, ram_data_out,
        output busy, done, pass, ram_we, ram_addr, ram_data_in
    );
    modport slave (
        output start, ram_data_out,
        input  busy, done, pass, ram_we, ram_addr, ram_data_in
    );
`endif
endinterface
`default_nettype wire

// File: rtl/ram_bist_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : ram_bist_addr_gen
// Description : Up/down address counter with load, enable and terminal flag.
// Revision    : 1.0
// ============================================================================
module ram_bist_addr_gen #(
    parameter int data_addr = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 load,
    input  wire logic                 load_down,
    input  wire logic                 en,
    input  wire logic                 down,
    output logic [data_addr-1:0]      cnt,
    output logic                      last
);
    localparam logic [data_addr-1:0] C_TOP = '1;
    localparam logic [data_addr-1:0] C_ONE = data_addr'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_down ? C_TOP : '0;
        end else if (en) begin
            cnt <= down ? (cnt - C_ONE) : (cnt + C_ONE);
        end
    end

    assign last = down ? (cnt == '0) : (cnt == C_TOP);

endmodule
`default_nettype wire

// File: rtl/ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_bist_ctrl
// Description : Four-element March BIST controller driving a single RAM port.
//               RAM_BIST_ERRLOG_EN adds first-miscompare address/data capture.
// Revision    : 1.0
// ============================================================================
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int data_width = 8,
    parameter int data_addr  = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    ram_bist_ctrl_if.master bus
);
    localparam logic [data_width-1:0] C_P0 = data_width'(p0_pattern(data_width));
    localparam logic [data_width-1:0] C_P1 = data_width'(p1_pattern(data_width));

    state_t                state;
    element_t              elem;
    logic                  we_q;
    logic [data_width-1:0] din_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  pass_q;
    logic                  cmp_cycle;
    logic [data_width-1:0] expected;
    logic                  miscompare;
    logic                  cnt_load;
    logic                  cnt_load_down;
    logic                  cnt_en;
    logic                  cnt_down;
    logic [data_addr-1:0]  cnt;
    logic                  cnt_last;

    assign elem       = element_of(state);
    assign cnt_down   = (elem == EL_R1W0);
    assign expected   = (elem == EL_R1W0) ? C_P1 : C_P0;
    assign cmp_cycle  = (state == ST_R0W1_WR) || (state == ST_R1W0_WR) || (state == ST_R0_CMP);
    assign miscompare = cmp_cycle && (bus.ram_data_out != expected);

    // Any exit to DONE reloads 0 so the address bus idles at zero.
    always_comb begin
        cnt_load      = 1'b0;
        cnt_load_down = 1'b0;
        cnt_en        = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_load = bus.start;
            end
            ST_W0: begin
                if (cnt_last) cnt_load = 1'b1;
                else          cnt_en   = 1'b1;
            end
            ST_R0W1_WR: begin
                if (miscompare) begin
                    cnt_load = 1'b1;
                end else if (cnt_last) begin
                    cnt_load      = 1'b1;
                    cnt_load_down = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_R1W0_WR, ST_R0_CMP: begin
                if (miscompare || cnt_last) cnt_load = 1'b1;
                else                        cnt_en   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    ram_bist_addr_gen #(
        .data_addr (data_addr)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .load_down (cnt_load_down),
        .en        (cnt_en),
        .down      (cnt_down),
        .cnt       (cnt),
        .last      (cnt_last)
    );

`ifdef RAM_BIST_ERRLOG_EN
    logic [data_addr-1:0]  fail_addr_q;
    logic [data_width-1:0] fail_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (state == ST_IDLE && bus.start) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (miscompare) begin
            fail_addr_q <= cnt;
            fail_data_q <= bus.ram_data_out;
        end
    end

    assign bus.fail_addr = fail_addr_q;
    assign bus.fail_data = fail_data_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            we_q   <= 1'b0;
            din_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state  <= ST_W0;
                        busy_q <= 1'b1;
                        pass_q <= 1'b0;
                        we_q   <= 1'b1;
                        din_q  <= C_P0;
                    end
                end
                ST_W0: begin
                    if (cnt_last) begin
                        state <= ST_R0W1_RD;
                        we_q  <= 1'b0;
                    end
                end
                ST_R0W1_RD: begin
                    state <= ST_R0W1_WR;
                    we_q  <= 1'b1;
                    din_q <= C_P1;
                end
                ST_R1W0_RD: begin
                    state <= ST_R1W0_WR;
                    we_q  <= 1'b1;
                    din_q <= C_P0;
                end
                ST_R0_RD: begin
                    state <= ST_R0_CMP;
                    we_q  <= 1'b0;
                end
                ST_R0W1_WR, ST_R1W0_WR, ST_R0_CMP: begin
                    we_q <= 1'b0;
                    if (miscompare) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= 1'b0;
                        din_q  <= '0;
                    end else if (state == ST_R0W1_WR) begin
                        state <= cnt_last ? ST_R1W0_RD : ST_R0W1_RD;
                    end else if (state == ST_R1W0_WR) begin
                        state <= cnt_last ? ST_R0_RD : ST_R1W0_RD;
                    end else if (cnt_last) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= 1'b1;
                    end else begin
                        state <= ST_R0_RD;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    we_q   <= 1'b0;
                end
            endcase
        end
    end

    // Only the miscompare path reaches ram_we combinationally: it vetoes the write.
    assign bus.ram_we      = we_q & ~miscompare;
    assign bus.ram_addr    = cnt;
    assign bus.ram_data_in = din_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;

endmodule
`default_nettype wire
